// File: rtl/csa_tree_window_accumulator.sv
// Gated-coefficient INPUT:2 carry-save tree with a CPA stage and
// a windowed energy accumulator for the power-emulator datapath.
module csa_tree_window_accumulator #(
    parameter int BITS  = 32,
    parameter int CGES  = 13,
    parameter int INPUT = 7,
    parameter int WIN_W = 16,
    parameter int MAX   = $clog2(CGES) + BITS,
    parameter int ACC_W = MAX + WIN_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [CGES-1:1]         cges,
    input  logic                    coef_we,
    input  logic [$clog2(CGES)-1:0] coef_addr,
    input  logic [BITS-1:0]         coef_wdata,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    win_clr,
    output logic [MAX-1:0]          vs,
    output logic [MAX-1:0]          vc,
    output logic [MAX-1:0]          inst_sum,
    output logic                    inst_valid,
    output logic [ACC_W-1:0]        win_sum,
    output logic                    win_valid
);

    function automatic int rows_at(input int lvl);
        int r;
        r = CGES;
        for (int k = 0; k < lvl; k++) begin
            if (r >= INPUT) r = 2 * (r / INPUT) + r % INPUT;
            else if (r > 2) r = 2;
        end
        return r;
    endfunction

    function automatic int n_stages();
        int n;
        n = 0;
        for (int k = 0; k < CGES; k++)
            if (rows_at(k) > 2) n = k + 1;
        return n;
    endfunction

    // Levels 1..LAT_T are packed back to back in one flat register.
    function automatic int lvl_off(input int lvl);
        int o;
        o = 0;
        for (int k = 1; k < lvl; k++) o = o + rows_at(k);
        return o;
    endfunction

    localparam int LAT_T   = n_stages();
    localparam int TOT     = lvl_off(LAT_T + 1);
    localparam int OUT_OFF = lvl_off(LAT_T);
    localparam logic [WIN_W-1:0] ONE = WIN_W'(1);

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    logic [BITS-1:0]     r_coef [CGES];
    logic [CGES*MAX-1:0] r_term;
    logic                r_in_vld;
    logic [TOT*MAX-1:0]  r_tree;
    logic [LAT_T-1:0]    r_vld;
    logic [MAX-1:0]      r_inst_sum;
    logic                r_inst_valid;
    logic [CGES*MAX-1:0] w_term;
    wire  [TOT*MAX-1:0]  w_tree;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CGES; i++) r_coef[i] <= '0;
        end else if (coef_we && 32'(coef_addr) < CGES) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    always_comb begin
        w_term = '0;
        w_term[0 +: MAX] = {{(MAX-BITS){r_coef[0][BITS-1]}}, r_coef[0]};
        for (int i = 1; i < CGES; i++)
            if (cges[i])
                w_term[i*MAX +: MAX] =
                    {{(MAX-BITS){r_coef[i][BITS-1]}}, r_coef[i]};
    end

    for (genvar s = 0; s < LAT_T; s++) begin : g_stage
        localparam int RI = rows_at(s);
        localparam int NG = (RI >= INPUT) ? RI / INPUT : 1;
        localparam int GS = (RI >= INPUT) ? INPUT : RI;
        localparam int NL = RI - NG * GS;
        localparam int OO = lvl_off(s + 1);

        logic [RI*MAX-1:0] w_in;

        if (s == 0) begin : g_src_term
            assign w_in = r_term;
        end else begin : g_src_tree
            assign w_in = r_tree[lvl_off(s)*MAX +: RI*MAX];
        end

        for (genvar g = 0; g < NG; g++) begin : g_grp
            logic [GS*MAX-1:0] w_grp;
            logic [MAX-1:0]    w_s, w_c, w_t, w_r;

            assign w_grp = w_in[g*GS*MAX +: GS*MAX];

            // Chain of 3:2 counters folding GS rows into a sum/carry pair.
            always_comb begin
                w_s = w_grp[0 +: MAX];
                w_c = w_grp[MAX +: MAX];
                w_t = '0;
                w_r = '0;
                for (int k = 2; k < GS; k++) begin
                    w_r = w_grp[k*MAX +: MAX];
                    w_t = w_s ^ w_c ^ w_r;
                    w_c = ((w_s & w_c) | (w_s & w_r) | (w_c & w_r)) << 1;
                    w_s = w_t;
                end
            end

            assign w_tree[(OO+2*g)*MAX +: 2*MAX] = {w_c, w_s};
        end

        if (NL > 0) begin : g_pass
            assign w_tree[(OO+2*NG)*MAX +: NL*MAX] =
                w_in[NG*GS*MAX +: NL*MAX];
        end
    end

    assign vs = r_tree[OUT_OFF*MAX +: MAX];
    assign vc = r_tree[(OUT_OFF+1)*MAX +: MAX];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_term       <= '0;
            r_in_vld     <= 1'b0;
            r_tree       <= '0;
            r_vld        <= '0;
            r_inst_sum   <= '0;
            r_inst_valid <= 1'b0;
        end else if (en) begin
            r_term       <= w_term;
            r_in_vld     <= in_valid;
            r_tree       <= w_tree;
            r_vld        <= LAT_T'({r_vld, r_in_vld});
            r_inst_sum   <= vs + vc;
            r_inst_valid <= r_vld[LAT_T-1];
        end
    end

    assign inst_sum   = r_inst_sum;
    assign inst_valid = r_inst_valid;

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt, w_acc_base, w_smp;
    logic [WIN_W-1:0] r_cnt, w_cnt_nxt, w_cnt_base;
    logic [WIN_W-1:0] r_len, w_len_nxt, w_len_in;
    logic [ACC_W-1:0] r_win_sum, w_win_sum_nxt;
    logic             r_win_valid, w_win_valid_nxt;
    logic             w_take, w_fresh, w_last;

    // A clear that meets a sample restarts the window with that sample.
    assign w_take     = r_inst_valid & en;
    assign w_fresh    = win_clr | (r_state == S_IDLE);
    assign w_len_in   = (win_len == '0) ? ONE : win_len;
    assign w_smp      = {{(ACC_W-MAX){r_inst_sum[MAX-1]}}, r_inst_sum};
    assign w_acc_base = w_fresh ? '0 : r_acc;
    assign w_cnt_base = w_fresh ? '0 : r_cnt;
    assign w_last     = w_fresh ? (w_len_in == ONE)
                                : (r_cnt + ONE == r_len);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_take)       w_state_nxt = w_last ? S_IDLE : S_ACC;
        else if (win_clr) w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_win_sum_nxt   = r_win_sum;
        w_win_valid_nxt = 1'b0;
        if (win_clr) begin
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
        end
        if (w_take) begin
            if (w_fresh) w_len_nxt = w_len_in;
            if (w_last) begin
                w_win_sum_nxt   = w_acc_base + w_smp;
                w_win_valid_nxt = 1'b1;
                w_acc_nxt       = '0;
                w_cnt_nxt       = '0;
            end else begin
                w_acc_nxt = w_acc_base + w_smp;
                w_cnt_nxt = w_cnt_base + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_win_sum   <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_win_sum   <= w_win_sum_nxt;
            r_win_valid <= w_win_valid_nxt;
        end
    end

    assign win_sum   = r_win_sum;
    assign win_valid = r_win_valid;

endmodule
